ff_bank_arbiter: RTL and testbench
==================================

// Module: ff_bank_arbiter
// PURPOSE
//   Round-robin write arbiter for one shared WIDTH-bit register: a bank of posedge D flip-flops, power-up 0.
//   Up to NUM_REQ requesters each offer a data word. The block grants one at a time, loads that word
//   into the register, acknowledges it, and waits for release before serving the next requester.
//   The register contents (q) are visible to all requesters and to downstream display/datapath logic.
// PARAMETERS
//   NUM_REQ  4  number of requesters, legal 2..8; ID_W = $clog2(NUM_REQ) (localparam)
//   WIDTH    8  width of the shared register and of each requester data word
// PORTS
//   clk      in   1              single clock; all state changes on posedge clk
//   reset    in   1              synchronous, active-high reset
//   req      in   NUM_REQ        req[i]=1: requester i wants to write; held until ack seen
//   wr_data  in   NUM_REQ*WIDTH  requester i word = wr_data[i*WIDTH +: WIDTH]
//   grant    out  NUM_REQ        one-hot, high for the single LOAD cycle of the winner
//   ack      out  NUM_REQ        one-hot, high for the single DONE cycle; q already holds new word
//   q        out  WIDTH          shared register contents
//   last_id  out  ID_W           index of most recent writer
//   busy     out  1              high in every state except IDLE
// BEHAVIOUR
//   Reset (reset=1 at posedge): state=IDLE, q=0, last_id=0, ptr=NUM_REQ-1 (req 0 wins first),
//     grant=0, ack=0, busy=0. Takes priority over everything; an in-flight transfer is aborted, no ack.
//   FSM (Moore; grant/ack/busy decoded from state and latched winner win):
//     IDLE: if |req: win <= first i with req[i]=1 scanning ptr+1, ptr+2, ... mod NUM_REQ; -> LOAD.
//           else stay.
//     LOAD: grant[win]=1. At the edge: q <= word of win; last_id <= win; ptr <= win; -> DONE.
//           The write commits even if req[win] dropped during LOAD.
//     DONE: ack[win]=1. If req[win]=0 -> IDLE, else -> WAIT.
//     WAIT: no grant/ack. If req[win]=0 -> IDLE. Blocks all other requesters meanwhile.
//   Latency: req seen in IDLE at cycle t -> grant t+1 -> q updated and ack at t+2 -> IDLE no earlier than t+3.
//   wr_data is sampled only at the LOAD edge; it is don't-care otherwise.
//   Fairness: a requester that just wrote has lowest priority next arbitration. Every continuously
//     asserting requester is served within NUM_REQ transactions.
//   Losing requests are not latched; a req dropped before winning is simply forgotten.
//   Simultaneous reqs: single winner per round-robin order; others remain pending (grant never multi-hot).
//   ptr wrap: after win=NUM_REQ-1, the scan starts at 0.
//   q changes only at a LOAD edge or reset; it is otherwise held indefinitely.
// TESTING
//   T1 reset: reset=1 one edge mid-LOAD (req=4'b0010) -> q=0, grant=0, ack=0, busy=0, no ack ever issued.
//   T2 single: req=4'b0100, word2=8'hA5 from IDLE at t -> grant=4'b0100 at t+1, q=8'hA5 & ack=4'b0100
//      at t+2, last_id=2; drop req at t+2 -> IDLE at t+3, busy=0.
//   T3 all request: req=4'b1111, words 11/22/33/44, each drops req on its ack and re-raises after IDLE
//      -> q sequence 8'h11,8'h22,8'h33,8'h44,8'h11; grant always one-hot.
//   T4 wrap: after last_id=3, req=4'b1001 -> requester 0 wins; then req=4'b1001 again -> 3 wins.
//   T5 sticky holder: requester 1 keeps req high 5 cycles after ack while req[0]=1 -> FSM in WAIT,
//      no grant to 0 until req[1]=0; then 0 granted next IDLE cycle +1.
//   T6 late drop: req[3] drops during LOAD with word3=8'h7E -> q=8'h7E, ack[3] pulses, DONE->IDLE.

Source files
------------

// File: rtl/ff_bank_arbiter.sv
// rtl/ff_bank_arbiter.sv - round-robin write arbiter for one shared WIDTH-bit register
// Grants one requester at a time, loads its word, acks, and holds until that requester releases.
module ff_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic [ID_W-1:0]          last_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [WIDTH-1:0]  win_word;
  logic              win_req;
  logic [NUM_REQ-1:0] win_oh;

  // Scan starts one past the last writer so it gets lowest priority; wraps for any NUM_REQ.
  always_comb begin
    pick  = '0;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_word = '0;
    win_req  = 1'b0;
    win_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        win_word  = wr_data[i*WIDTH +: WIDTH];
        win_req   = req[i];
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant   = '0;
    ack     = '0;
    busy    = (state != IDLE);
    case (state)
      IDLE: begin
        if (|req) state_n = LOAD;
      end
      LOAD: begin
        grant   = win_oh;
        state_n = DONE;
      end
      DONE: begin
        ack     = win_oh;
        state_n = win_req ? WAIT : IDLE;
      end
      WAIT: begin
        if (!win_req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The LOAD edge commits unconditionally, even if the winner already dropped req.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      win     <= '0;
      ptr     <= ID_W'(NUM_REQ - 1);
      q       <= '0;
      last_id <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) win <= pick;
      if (state == LOAD) begin
        q       <= win_word;
        last_id <= win;
        ptr     <= win;
      end
    end
  end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// tb/tb_ff_bank_arbiter.sv - scoreboard bench for ff_bank_arbiter
// Transaction-level reference model predicts grants/acks; a negedge monitor checks them.
module tb_ff_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [1:0]     last_id;
  logic           busy;

  ff_bank_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wr_data(wr_data),
    .grant(grant), .ack(ack), .q(q), .last_id(last_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    int         id;
    logic [W-1:0] word;
  } exp_t;

  exp_t grant_q[$];
  exp_t ack_q[$];

  int           m_owner = -1;
  int           m_rr    = N - 1;
  int           m_last  = 0;
  logic         m_loaded = 1'b0;
  logic [W-1:0] m_q     = '0;

  int  hold [N];
  bit  acked[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit rbit(input logic [N-1:0] r, input int i);
    logic [N-1:0] t;
    t = r >> i;
    return t[0];
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int base);
    for (int k = 1; k <= N; k++)
      if (rbit(r, (base + k) % N)) return (base + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] word_of(input logic [N*W-1:0] d, input int i);
    logic [N*W-1:0] s;
    s = d >> (i * W);
    return s[W-1:0];
  endfunction

  // Model: free -> winner chosen; next edge writes and acks; then held until winner releases.
  task automatic model_step(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] d);
    exp_t e;
    if (rst) begin
      m_owner = -1; m_rr = N - 1; m_last = 0; m_q = '0; m_loaded = 1'b0;
      grant_q.delete();
      ack_q.delete();
      return;
    end
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner  = rr_pick(r, m_rr);
        m_loaded = 1'b0;
        e = '{cyc, m_owner, '0};
        grant_q.push_back(e);
      end
    end else if (!m_loaded) begin
      m_loaded = 1'b1;
      m_q      = word_of(d, m_owner);
      m_last   = m_owner;
      m_rr     = m_owner;
      e = '{cyc, m_owner, m_q};
      ack_q.push_back(e);
    end else if (!rbit(r, m_owner)) begin
      m_owner = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #2;
    model_step(reset, req, wr_data);
  endtask

  task automatic monitor_cycle();
    exp_t e;
    logic [N-1:0] oh;
    if (grant != '0 || (grant_q.size() > 0 && grant_q[0].cyc <= cyc)) begin
      if (grant_q.size() == 0) check("grant_unexpected", 32'(grant), 32'(0));
      else begin
        e  = grant_q.pop_front();
        oh = N'(1) << e.id;
        check("grant_cycle", 32'(cyc), 32'(e.cyc));
        check("grant_id", 32'(grant), 32'(oh));
      end
    end
    if (ack != '0 || (ack_q.size() > 0 && ack_q[0].cyc <= cyc)) begin
      if (ack_q.size() == 0) check("ack_unexpected", 32'(ack), 32'(0));
      else begin
        e  = ack_q.pop_front();
        oh = N'(1) << e.id;
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_id", 32'(ack), 32'(oh));
        check("ack_q_word", 32'(q), 32'(e.word));
      end
    end
    check("q_held", 32'(q), 32'(m_q));
    check("last_id", 32'(last_id), 32'(m_last));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("grant_onehot0", 32'($onehot0(grant)), 32'(1));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) monitor_cycle();
    end
  end

  initial begin
    logic [W-1:0] seq [5];
    int id;
    int waited;
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    reset = 1'b1; req = '0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // single requester latency
    req = 4'b0100; wr_data[2*W +: W] = 8'hA5;
    tick(); check("t2_grant", 32'(grant), 32'(4'b0100));
    tick(); check("t2_q", 32'(q), 32'(8'hA5)); check("t2_ack", 32'(ack), 32'(4'b0100));
    check("t2_last_id", 32'(last_id), 32'(2));
    req = '0;
    tick(); check("t2_idle", 32'(busy), 32'(0));

    // wrap: after 3 writes, 0 wins, then 3
    req = 4'b1000; wr_data[3*W +: W] = 8'h44;
    tick(); tick(); req = '0; tick();
    req = 4'b1001; wr_data[0 +: W] = 8'h10;
    tick(); check("t4_grant0", 32'(grant), 32'(4'b0001));
    tick(); req = 4'b1000;
    tick(); tick(); check("t4_grant3", 32'(grant), 32'(4'b1000));
    tick(); check("t4_last3", 32'(last_id), 32'(3));
    req = '0; tick();

    // reset mid-LOAD aborts the write
    req = 4'b0010; wr_data[1*W +: W] = 8'h5A;
    tick(); check("t1_grant", 32'(grant), 32'(4'b0010));
    reset = 1'b1; tick(); reset = 1'b0; req = '0;
    check("t1_q", 32'(q), 32'(0)); check("t1_grant0", 32'(grant), 32'(0));
    check("t1_ack0", 32'(ack), 32'(0)); check("t1_busy", 32'(busy), 32'(0));
    tick(); tick(); tick();

    // all request: round-robin order 0,1,2,3,0
    wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      do begin tick(); waited++; end while (ack == '0 && waited < 12);
      check("t3_ack_seen", 32'(ack != '0), 32'(1));
      check("t3_q_seq", 32'(q), 32'(seq[n]));
      id = 0;
      for (int i = 0; i < N; i++) if (ack[i]) id = i;
      req[id] = 1'b0;
      tick();
      req[id] = 1'b1;
    end
    req = '0; tick(); tick(); tick();

    // randomized requesters with sticky holds, late drops, abandons and resets
    for (int i = 0; i < N; i++) begin hold[i] = 0; acked[i] = 0; end
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1; acked[i] = 0;
            wr_data[i*W +: W] = W'($urandom);
          end
        end else if (ack[i]) begin
          if ($urandom_range(0, 2) != 0) req[i] = 1'b0;
          else begin acked[i] = 1; hold[i] = $urandom_range(1, 5); end
        end else if (acked[i]) begin
          hold[i]--;
          if (hold[i] <= 0) req[i] = 1'b0;
        end else if (grant[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    reset = 1'b0; req = '0;
    repeat (6) tick();
    check("drain_idle", 32'(busy), 32'(0));
    check("grant_q_empty", 32'(grant_q.size()), 32'(0));
    check("ack_q_empty", 32'(ack_q.size()), 32'(0));
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
